data_mem_sram_ctrl: RTL and testbench

- Responder for the CPU memory-stage data access handshake.
- Accepts one word request (address, write data, byte enables, read/write), runs it as two 16-bit accesses on an external asynchronous SRAM, and returns a single-cycle ack with read data.
- The hazard unit holds the memory stage stalled while ack is low.

---
 rtl/data_mem_sram_ctrl.sv | 168 ++++++++++++++++
 tb/tb_data_mem_sram_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sram_ctrl.sv
// Memory-stage data port: runs each 32-bit request as two 16-bit phases on an
// asynchronous SRAM and answers with a one-cycle ack. All outputs are registered.
module data_mem_sram_ctrl #(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               wr,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         byte_en,
  output logic [31:0]        rdata,
  output logic               ack,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES);

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;

  logic              op_wr;
  logic [SRAM_AW-2:0] op_addr;
  logic [31:0]       op_wdata;
  logic [3:0]        op_be;

  logic              cur_wr;
  logic [SRAM_AW-2:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_be;

  logic               ack_d, dq_oe_d, ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, half_d;
  logic [SRAM_AW-1:0] addr_d;
  logic [15:0]        dq_out_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:SRAM_AW+1], addr[1:0]};

  // In IDLE the outgoing SRAM controls must already reflect the request being accepted
  assign cur_wr    = (state == IDLE) ? wr               : op_wr;
  assign cur_addr  = (state == IDLE) ? addr[SRAM_AW:2]  : op_addr;
  assign cur_wdata = (state == IDLE) ? wdata            : op_wdata;
  assign cur_be    = (state == IDLE) ? byte_en          : op_be;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        cnt_d = RELOAD;
        if (req) begin
          if (!wr || (|byte_en[1:0])) state_d = LO;
          else if (|byte_en[3:2])     state_d = HI;
          else                        state_d = ACK;
        end
      end
      LO: begin
        if (cnt == 4'd0) begin
          cnt_d   = RELOAD;
          state_d = (!op_wr || (|op_be[3:2])) ? HI : ACK;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      HI: begin
        if (cnt == 4'd0) state_d = ACK;
        else             cnt_d   = cnt - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the cycle that follows, derived from the upcoming state and count
  always_comb begin
    ack_d    = (state_d == ACK);
    addr_d   = sram_addr;
    dq_out_d = sram_dq_out;
    dq_oe_d  = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    half_d   = (state_d == HI);
    if (state_d == LO || state_d == HI) begin
      addr_d = {cur_addr, half_d};
      ce_n_d = 1'b0;
      if (cur_wr) begin
        dq_oe_d  = 1'b1;
        dq_out_d = half_d ? cur_wdata[31:16] : cur_wdata[15:0];
        lb_n_d   = half_d ? ~cur_be[2] : ~cur_be[0];
        ub_n_d   = half_d ? ~cur_be[3] : ~cur_be[1];
        we_n_d   = (cnt_d == 4'd0);
      end else begin
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_wr    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= 32'd0;
      op_be    <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && req) begin
        op_wr    <= wr;
        op_addr  <= addr[SRAM_AW:2];
        op_wdata <= wdata;
        op_be    <= byte_en;
      end
    end
  end

  // Read halves are captured at the end of their phase, while OE has been low a full phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= 32'd0;
    end else if (!op_wr && cnt == 4'd0) begin
      if (state == LO) rdata[15:0]  <= sram_dq_in;
      if (state == HI) rdata[31:16] <= sram_dq_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack         <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      ack         <= ack_d;
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= dq_oe_d;
      sram_ce_n   <= ce_n_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
      sram_ub_n   <= ub_n_d;
      sram_lb_n   <= lb_n_d;
    end
  end

endmodule

// File: tb/tb_data_mem_sram_ctrl.sv
// Bench for data_mem_sram_ctrl: behavioural SRAM plus a word/lane reference memory,
// directed cases followed by random transfers.
module tb_data_mem_sram_ctrl;
  localparam int AW = 18;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, wr;
  logic [31:0]   addr, wdata, rdata;
  logic [3:0]    byte_en;
  logic          ack;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  data_mem_sram_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .byte_en(byte_en), .rdata(rdata), .ack(ack), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic [15:0] ref_mem  [0:(1<<AW)-1];

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_dq_out[7:0];
      if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_dq_out[15:8];
    end
  end

  int n_cmp = 0, n_fail = 0;
  int ce_low, we_low, oe_low, lo_cyc, hi_cyc, bad_addr, bad_lane;
  bit contention = 0, dbl_ack = 0, prev_ack = 0;
  logic        cur_wr;
  logic [31:0] cur_addr;
  logic [3:0]  cur_be;
  logic [1:0]  lanes, exp_ublb;
  logic [31:0] exp_rdata;

  // Bus activity observed away from the clock edge
  always @(negedge clk) begin
    if (sram_dq_oe && !sram_oe_n) contention = 1;
    if (ack && prev_ack) dbl_ack = 1;
    prev_ack = ack;
    if (!sram_ce_n) begin
      ce_low++;
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (sram_addr[AW-1:1] !== cur_addr[AW:2]) bad_addr++;
      if (sram_addr[0]) hi_cyc++; else lo_cyc++;
      lanes    = sram_addr[0] ? cur_be[3:2] : cur_be[1:0];
      exp_ublb = cur_wr ? ~lanes : 2'b00;
      if ({sram_ub_n, sram_lb_n} !== exp_ublb) bad_lane++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input bit hold, input bit chained);
    int lo_ph, hi_ph, exp_lat, cycles;
    bit got;
    logic [AW-1:0] h0, h1;
    lo_ph   = (!w || (|be[1:0])) ? 1 : 0;
    hi_ph   = (!w || (|be[3:2])) ? 1 : 0;
    exp_lat = (lo_ph + hi_ph) * (W + 1) + 1 + (chained ? 1 : 0);
    h0 = {a[AW:2], 1'b0};
    h1 = {a[AW:2], 1'b1};
    cur_wr = w; cur_addr = a; cur_be = be;
    ce_low = 0; we_low = 0; oe_low = 0; lo_cyc = 0; hi_cyc = 0; bad_addr = 0; bad_lane = 0;
    wr = w; addr = a; wdata = d; byte_en = be; req = 1'b1;
    cycles = 0; got = 0;
    while (!got && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (!hold && cycles == (chained ? 2 : 1)) req = 1'b0;
      if (ack) got = 1;
    end
    checkOutput("ack_seen", 32'(got), 32'd1);
    checkOutput("latency", cycles, exp_lat);
    if (w) begin
      if (be[0]) ref_mem[h0][7:0]  = d[7:0];
      if (be[1]) ref_mem[h0][15:8] = d[15:8];
      if (be[2]) ref_mem[h1][7:0]  = d[23:16];
      if (be[3]) ref_mem[h1][15:8] = d[31:24];
    end else begin
      exp_rdata = {ref_mem[h1], ref_mem[h0]};
    end
    checkOutput("rdata", rdata, exp_rdata);
    checkOutput("ce_low_cycles", ce_low, (lo_ph + hi_ph) * (W + 1));
    checkOutput("we_low_cycles", we_low, w ? (lo_ph + hi_ph) * W : 0);
    checkOutput("oe_low_cycles", oe_low, w ? 0 : 2 * (W + 1));
    checkOutput("lo_cycles", lo_cyc, lo_ph * (W + 1));
    checkOutput("hi_cycles", hi_cyc, hi_ph * (W + 1));
    checkOutput("addr_errs", bad_addr, 0);
    checkOutput("lane_errs", bad_lane, 0);
    checkOutput("contention", 32'(contention), 32'd0);
    checkOutput("double_ack", 32'(dbl_ack), 32'd0);
    if (w) begin
      checkOutput("mem_lo", 32'(sram_mem[h0]), 32'(ref_mem[h0]));
      checkOutput("mem_hi", 32'(sram_mem[h1]), 32'(ref_mem[h1]));
    end
    if (!hold) begin
      @(posedge clk); #1;
      checkOutput("ack_pulse_end", 32'(ack), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < (1 << AW); i++) begin
      v = 16'($urandom);
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_mem[18'h82] = 16'hBEEF; ref_mem[18'h82] = 16'hBEEF;
    sram_mem[18'h83] = 16'hDEAD; ref_mem[18'h83] = 16'hDEAD;
    exp_rdata = 32'd0;
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; byte_en = 4'd0;
    cur_wr = 1'b0; cur_addr = 32'd0; cur_be = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_ctrl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'b111110);
    checkOutput("rst_addr", 32'(sram_addr), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b0, 32'h0000_0104, 32'd0, 4'b0000, 1'b0, 1'b0);
    checkOutput("read_deadbeef", rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 1'b0, 1'b0);
    checkOutput("full_wr_hw8", 32'(sram_mem[18'h8]), 32'h5678);
    checkOutput("full_wr_hw9", 32'(sram_mem[18'h9]), 32'h1234);
    applyStimulus(1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 4'b0100, 1'b0, 1'b0);
    checkOutput("byte_wr_rdata_kept", rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h0000_0030, 32'h5555_5555, 4'b0000, 1'b0, 1'b0);

    applyStimulus(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0000_0040, 32'd0, 4'b0000, 1'b0, 1'b1);
    checkOutput("b2b_readback", rdata, 32'hCAFEF00D);

    cur_wr = 1'b0; cur_addr = 32'h0000_0104; cur_be = 4'd0;
    wr = 1'b0; addr = 32'h0000_0104; req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("midrst_ctrl", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}), 32'b111110);
    checkOutput("midrst_ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    checkOutput("midrst_hold_ce", 32'(sram_ce_n), 32'd1);
    reset = 1'b0;
    exp_rdata = 32'd0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0000_0104, 32'd0, 4'b0000, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [31:0] ra;
      ra = ($urandom & 32'hFFF8_0000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(1'($urandom), ra, $urandom, 4'($urandom), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
